mont_product: RTL and testbench
===============================

// Module: mont_product
// PURPOSE
// - Bit-serial Montgomery multiplier for the RSA core: result = a*b*2^-W mod N.
// - Directly downstream of the pre-processing stage: consumes its T = M*2^W mod N
//   (plus N and key-driven operands) inside the square-and-multiply loop.
// - One iteration per clock, then one conditional final subtraction; start/finish handshake.
// PARAMETERS
// - W      256             operand width in bits (modulus, operands, result)
// - CNT_W  $clog2(W)       iteration counter width (derived, do not override)
// PORTS
// - clk       in   1   rising-edge clock
// - rst_n     in   1   asynchronous active-low reset
// - start     in   1   request; sampled only while idle (ready_o=1)
// - a_i       in   W   multiplicand, must be < n_i
// - b_i       in   W   multiplier, must be < n_i
// - n_i       in   W   modulus, must be odd and nonzero
// - ready_o   out  1   1 in IDLE: block accepts start
// - result_o  out  W   a*b*2^-W mod N; held from finish until next finish
// - finish    out  1   one-cycle pulse: result_o valid
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE, acc=0, cnt=0, result_o=0, finish=0, ready_o=1.
// - Reset mid-operation aborts immediately; no finish pulse for the aborted job.
// - IDLE: ready_o=1. start=1 at an edge latches a_i, b_i, n_i into internal regs,
//   clears acc (W+2 bits), cnt=0 -> CALC. Inputs may change after the latching edge.
// - CALC: ready_o=0; each edge, with i=cnt:
//   t = acc + (a_reg[i] ? b_reg : 0); if t odd, t = t + n_reg; acc = t >> 1.
//   cnt==W-1 -> SUB, else cnt=cnt+1. Exactly W CALC cycles.
// - SUB: one edge: result_o = (acc >= n_reg) ? acc - n_reg : acc[W-1:0];
//   finish=1 (registered) -> IDLE.
// - Latency: start sampled at edge k -> finish high during the cycle after edge k+W+1;
//   next start may be sampled on that same cycle (finish and ready_o both 1).
// - finish is high exactly one cycle; cleared on the following edge unconditionally.
// - start while ready_o=0: ignored, not queued; running job unaffected.
// - Width rule: acc < 2N holds every iteration given a,b < N; acc kept W+2 bits,
//   no truncation until SUB; result_o always < n_i for legal inputs.
// - a_i=0 or b_i=0 -> result 0. Illegal inputs (even N, operands >= N): result
//   undefined but latency and handshake unchanged; no hang.
// STRUCTURE
// - Shared package rsa_pkg: W default constant, state enum {IDLE, CALC, SUB}.
// - Sub-module mont_step (combinational): (acc, a_bit, b, n) -> next acc; one
//   instance, keeps the datapath separable for a later radix-4 variant.
// - Top: state FSM, counter, operand regs, result reg.
// TESTING (run with W=8 unless stated)
// - N=13, a=5, b=7, start one cycle -> finish after W+1=9 cycles, result_o=1.
// - N=13, a=12, b=12 -> result_o=3; N=13, a=1, b=1 -> result_o=3 (2^-8 mod 13).
// - N=13, a=0, b=9 -> result_o=0; finish timing identical to nonzero case.
// - start held high continuously, N=13,a=5,b=7 -> back-to-back jobs, finish every
//   10 cycles, start during CALC ignored, each result_o=1.
// - rst_n low at CALC cycle 4 -> outputs at reset values at once, no finish;
//   new start after release gives correct result.
// - W=256: N=RSA-256 test modulus, a=T from pre-processing, b=1 -> result_o=M
//   (mod N); compare against software model for 1000 random a,b < N.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA datapath blocks.
//   W_DEFAULT : default operand width (modulus, operands, result)
//   state_e   : Montgomery multiplier control states
package rsa_pkg;
    localparam int W_DEFAULT = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SUB  = 2'd2
    } state_e;
endpackage

// File: rtl/mont_step.sv
// One radix-2 Montgomery iteration (combinational).
//   acc_i   : running accumulator, W+2 bits (< 2N for legal operands)
//   a_bit_i : current multiplicand bit
//   b_i     : multiplier
//   n_i     : odd modulus
//   acc_o   : (acc + a_bit*b [+ n if odd]) / 2
module mont_step
    import rsa_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic [W+1:0] acc_i,
    input  logic         a_bit_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] n_i,
    output logic [W+1:0] acc_o
);
    // One spare bit so the partial sum cannot wrap before halving.
    logic [W+2:0] t_add;

    assign t_add = {1'b0, acc_i} + (a_bit_i ? {3'b000, b_i} : '0);

    // (t + n) >> 1 == (t >> 1) + (n >> 1) + (t[0] & n[0]); when t is odd the
    // carry term is simply n[0]. Halving before the add keeps every bit live.
    assign acc_o = t_add[W+2:1]
                 + (t_add[0] ? ({3'b000, n_i[W-1:1]} + {{(W+1){1'b0}}, n_i[0]})
                             : '0);
endmodule

// File: rtl/mont_product.sv
// Bit-serial Montgomery multiplier: result_o = a*b*2^-W mod N.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request, sampled only while ready_o=1
//   a_i, b_i   : operands (< n_i), latched on the accepting edge
//   n_i        : odd nonzero modulus, latched on the accepting edge
//   ready_o    : idle, start will be accepted
//   result_o   : product, held until the next finish
//   finish     : one-cycle pulse, result_o valid
// Timing: start at edge k -> W CALC edges -> SUB edge k+W+1 raises finish.
module mont_product
    import rsa_pkg::*;
#(
    parameter  int W     = W_DEFAULT,
    localparam int CNT_W = $clog2(W)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] n_i,
    output logic         ready_o,
    output logic [W-1:0] result_o,
    output logic         finish
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(W - 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [W-1:0]     a_q, b_q, n_q;
    logic [W+1:0]     acc_q, acc_d;
    logic [W-1:0]     result_q, result_d;
    logic             finish_q;

    mont_step #(.W(W)) u_step (
        .acc_i   (acc_q),
        .a_bit_i (a_q[cnt_q]),
        .b_i     (b_q),
        .n_i     (n_q),
        .acc_o   (acc_d)
    );

    // Final conditional subtraction. Only the low W bits survive, so the
    // subtraction can be done at W bits (modular wrap gives the same result).
    always_comb begin
        result_d = acc_q[W-1:0];
        if (acc_q >= {2'b00, n_q})
            result_d = acc_q[W-1:0] - n_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            n_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
            finish_q <= 1'b0;
        end else begin
            finish_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a_i;
                        b_q     <= b_i;
                        n_q     <= n_i;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    if (cnt_q == LAST)
                        state_q <= SUB;
                    else
                        cnt_q <= cnt_q + CNT_W'(1);
                end
                SUB: begin
                    result_q <= result_d;
                    finish_q <= 1'b1;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready_o  = (state_q == IDLE);
    assign result_o = result_q;
    assign finish   = finish_q;
endmodule

// File: tb/tb_mont_product.sv
module tb_mont_product;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a_i, b_i, n_i;
    logic         ready_o;
    logic [W-1:0] result_o;
    logic         finish;

    int errors = 0;
    int checks = 0;

    mont_product #(.W(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a_i      (a_i),
        .b_i      (b_i),
        .n_i      (n_i),
        .ready_o  (ready_o),
        .result_o (result_o),
        .finish   (finish)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference: the unique x < n with x*2^W == a*b (mod n), found by search.
    function automatic longint mont_ref(input longint a, input longint b, input longint n);
        longint target;
        target = (a * b) % n;
        for (longint x = 0; x < n; x++)
            if (((x << W) % n) == target) return x;
        return -1;
    endfunction

    // ---------------- behavioural model: handshake timing + result ----------
    typedef struct {
        int           fin_e;
        longint       res;
        bit           known;
    } job_t;

    job_t   jobs[$];
    int     e;          // number of rising edges since reset
    int     free_e;     // first edge at which a new start can be accepted
    bit     exp_fin;
    longint exp_res;
    bit     exp_known;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            jobs.delete();
            e = 0; free_e = 0; exp_fin = 0; exp_res = 0; exp_known = 1;
        end else begin
            job_t j;
            e++;
            exp_fin = 0;
            if (jobs.size() > 0 && jobs[0].fin_e == e) begin
                exp_fin   = 1;
                exp_res   = jobs[0].res;
                exp_known = jobs[0].known;
                void'(jobs.pop_front());
            end
            if (start && e >= free_e) begin
                j.fin_e = e + W + 1;
                j.known = (n_i[0] == 1'b1) && (a_i < n_i) && (b_i < n_i);
                j.res   = j.known ? mont_ref(a_i, b_i, n_i) : 0;
                jobs.push_back(j);
                free_e  = e + W + 2;
            end
        end
    end

    // Compare process: every falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_ready", ready_o, 1);
            chk("rst_finish", finish, 0);
            chk("rst_result", result_o, 0);
        end else begin
            chk("ready", ready_o, (e + 1 >= free_e) ? 1 : 0);
            chk("finish", finish, exp_fin);
            if (exp_known) chk("result", result_o, exp_res);
        end
    end

    // ---------------- directed stimulus -------------------------------------
    // Entered just after a falling edge; returns just after a falling edge.
    task automatic run_job(input int a, input int b, input int n,
                           input bit chk_res, input longint exp);
        int cnt = 0;
        bit got = 0;
        a_i = W'(a); b_i = W'(b); n_i = W'(n); start = 1;
        @(posedge clk); #1;
        start = 0;
        a_i = ~W'(a); b_i = ~W'(b); n_i = ~W'(n);   // operands must be latched
        while (cnt < 3 * W && !got) begin
            @(posedge clk); cnt++;
            @(negedge clk);
            if (finish) got = 1;
        end
        chk("job_finish_seen", got, 1);
        chk("job_latency", cnt, W + 1);
        if (chk_res) chk("job_result", result_o, exp);
    endtask

    initial begin
        int fin_e[3];
        int nfin;
        rst_n = 0; start = 0; a_i = 0; b_i = 0; n_i = 0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1;
        @(negedge clk);

        // Pin the reference model against hand-computed values (2^-8 mod 13 = 3).
        chk("ref_5x7", mont_ref(5, 7, 13), 1);
        chk("ref_12x12", mont_ref(12, 12, 13), 3);
        chk("ref_1x1", mont_ref(1, 1, 13), 3);
        chk("ref_0x9", mont_ref(0, 9, 13), 0);

        run_job(5, 7, 13, 1, 1);
        run_job(12, 12, 13, 1, 3);
        run_job(1, 1, 13, 1, 3);
        run_job(0, 9, 13, 1, 0);
        run_job(9, 0, 13, 1, 0);
        run_job(250, 249, 251, 1, mont_ref(250, 249, 251));
        run_job(100, 37, 211, 1, mont_ref(100, 37, 211));
        run_job(5, 7, 12, 0, 0);        // even modulus: handshake only
        run_job(200, 7, 13, 0, 0);      // operand >= N: handshake only

        // start held high: back-to-back jobs, one every W+2 edges.
        a_i = 5; b_i = 7; n_i = 13; start = 1;
        nfin = 0;
        for (int c = 0; c < 6 * (W + 2) && nfin < 3; c++) begin
            @(negedge clk);
            if (finish) begin
                fin_e[nfin] = e;
                chk("b2b_result", result_o, 1);
                nfin++;
            end
        end
        start = 0;
        chk("b2b_count", nfin, 3);
        if (nfin == 3) begin
            chk("b2b_gap1", fin_e[1] - fin_e[0], W + 2);
            chk("b2b_gap2", fin_e[2] - fin_e[1], W + 2);
        end
        repeat (2) @(negedge clk);

        // Reset during CALC (4th iteration): abort, no finish.
        a_i = 5; b_i = 7; n_i = 13; start = 1;
        @(posedge clk); #1 start = 0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("abort_ready", ready_o, 1);
        chk("abort_finish", finish, 0);
        chk("abort_result", result_o, 0);
        @(negedge clk);
        #2 rst_n = 1;
        repeat (W + 4) @(negedge clk);
        run_job(5, 7, 13, 1, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
